// File: rtl/tmds_8b10b_encoder_pkg.sv
// tmds_pkg: shared TMDS definitions for the transmit encoder (and the
// matching receive decoder).
//   - tmds_mode_e  : symbol type selected per word
//   - CTRL_xx      : control tokens selected by {c1,c0}
//   - TERC4_x      : TERC4 code table
//   - GUARD_VID_xx : video guard-band words per channel
// Helper functions map sync bits / TERC4 nibbles onto their 10-bit codes.
// The TERC4 helper is only referenced when TMDS_TERC4_EN is defined.
package tmds_pkg;

    typedef enum logic [1:0] {
        MODE_CTRL  = 2'b00,
        MODE_VIDEO = 2'b01,
        MODE_GUARD = 2'b10,
        MODE_TERC4 = 2'b11
    } tmds_mode_e;

    localparam logic [9:0] CTRL_00 = 10'h354;
    localparam logic [9:0] CTRL_01 = 10'h0AB;
    localparam logic [9:0] CTRL_10 = 10'h154;
    localparam logic [9:0] CTRL_11 = 10'h2AB;

    localparam logic [9:0] TERC4_0 = 10'h29C;
    localparam logic [9:0] TERC4_1 = 10'h263;
    localparam logic [9:0] TERC4_2 = 10'h2E4;
    localparam logic [9:0] TERC4_3 = 10'h2E2;
    localparam logic [9:0] TERC4_4 = 10'h171;
    localparam logic [9:0] TERC4_5 = 10'h11E;
    localparam logic [9:0] TERC4_6 = 10'h18E;
    localparam logic [9:0] TERC4_7 = 10'h13C;
    localparam logic [9:0] TERC4_8 = 10'h2CC;
    localparam logic [9:0] TERC4_9 = 10'h139;
    localparam logic [9:0] TERC4_A = 10'h19C;
    localparam logic [9:0] TERC4_B = 10'h2C6;
    localparam logic [9:0] TERC4_C = 10'h28E;
    localparam logic [9:0] TERC4_D = 10'h271;
    localparam logic [9:0] TERC4_E = 10'h163;
    localparam logic [9:0] TERC4_F = 10'h2C3;

    localparam logic [9:0] GUARD_VID_02 = 10'h2CC;
    localparam logic [9:0] GUARD_VID_1  = 10'h133;

    // Control token for the {c1,c0} pair.
    function automatic logic [9:0] ctrl_token(input logic [1:0] sync);
        logic [9:0] tok;
        case (sync)
            2'b00:   tok = CTRL_00;
            2'b01:   tok = CTRL_01;
            2'b10:   tok = CTRL_10;
            2'b11:   tok = CTRL_11;
            default: tok = CTRL_00;
        endcase
        return tok;
    endfunction

    // TERC4 code for a 4-bit nibble.
    function automatic logic [9:0] terc4_code(input logic [3:0] nib);
        logic [9:0] code;
        case (nib)
            4'h0:    code = TERC4_0;
            4'h1:    code = TERC4_1;
            4'h2:    code = TERC4_2;
            4'h3:    code = TERC4_3;
            4'h4:    code = TERC4_4;
            4'h5:    code = TERC4_5;
            4'h6:    code = TERC4_6;
            4'h7:    code = TERC4_7;
            4'h8:    code = TERC4_8;
            4'h9:    code = TERC4_9;
            4'hA:    code = TERC4_A;
            4'hB:    code = TERC4_B;
            4'hC:    code = TERC4_C;
            4'hD:    code = TERC4_D;
            4'hE:    code = TERC4_E;
            4'hF:    code = TERC4_F;
            default: code = TERC4_0;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/tmds_8b10b_encoder_if.sv
// tmds_8b10b_encoder_if: per-channel encoder bus.
//   mode (2) symbol type, data (8) pixel byte, sync (2) {c1,c0},
//   ctrl (4) TERC4 nibble, out (10) encoded symbol, disp (6) signed
//   running disparity after the current out word.
// master drives the word inputs; slave is the encoder side.
interface tmds_8b10b_encoder_if;
    import tmds_pkg::*;

    tmds_mode_e  mode;
    logic [7:0]  data;
    logic [1:0]  sync;
    logic [3:0]  ctrl;
    logic [9:0]  out;
    logic [5:0]  disp;

    modport master (output mode, data, sync, ctrl, input out, disp);
    modport slave  (input mode, data, sync, ctrl, output out, disp);
endinterface

// File: rtl/tmds_8b10b_encoder_popcount8.sv
// tmds_popcount8: combinational count of ones in an 8-bit word.
//   bits  (in, 8)  word to count
//   count (out, 4) number of set bits, 0..8
module tmds_popcount8 (
    input  logic [7:0] bits,
    output logic [3:0] count
);

    // Sum the individual bits.
    always_comb begin
        count = 4'd0;
        for (int i = 0; i < 8; i++) begin
            count = count + {3'b000, bits[i]};
        end
    end

endmodule

// File: rtl/tmds_8b10b_encoder.sv
// tmds_8b10b_encoder: one-channel TMDS transmit encoder, one 10-bit symbol
// per clk, LSB first on the wire.
//   clk     pixel clock
//   reset_n asynchronous active-low reset
//   bus     tmds_8b10b_encoder_if.slave (mode/data/sync/ctrl in, out/disp out)
// Parameter CHANNEL (0..2) selects the video guard-band word.
// Macro TMDS_TERC4_EN: when defined, mode 11 emits the TERC4 code for ctrl;
// when undefined, mode 11 behaves as CTRL and no TERC4 logic is built.
// Two stages: stage 1 registers the transition-minimised q_m and the word
// controls; stage 2 applies DC balancing and registers out/disp.
module tmds_8b10b_encoder
    import tmds_pkg::*;
#(
    parameter int CHANNEL = 0
) (
    input  logic                        clk,
    input  logic                        reset_n,
    tmds_8b10b_encoder_if.slave         bus
);

    localparam logic [9:0] GUARD_WORD = (CHANNEL == 1) ? GUARD_VID_1 : GUARD_VID_02;

    // Stage 1
    logic [3:0]  n1_data_s;
    logic        use_xnor_s;
    logic [8:0]  qm_s;
    tmds_mode_e  mode_r;
    logic [1:0]  sync_r;
    logic [8:0]  qm_r;
`ifdef TMDS_TERC4_EN
    logic [3:0]  ctrl_r;
`endif

    // Stage 2
    logic [3:0]  n1_s;
    logic [3:0]  n0_s;
    logic [5:0]  diff_s;
    logic [7:0]  q_s;
    logic [9:0]  out_s;
    logic [5:0]  cnt_s;
    logic [9:0]  out_r;
    logic [5:0]  cnt_r;

    tmds_popcount8 u_pop_data (.bits(bus.data), .count(n1_data_s));

    // Transition-minimising chain: XNOR for ones-heavy bytes, else XOR.
    always_comb begin
        logic [7:0] chain;
        use_xnor_s = (n1_data_s > 4'd4) || ((n1_data_s == 4'd4) && (bus.data[0] == 1'b0));
        chain      = 8'h00;
        chain[0]   = bus.data[0];
        for (int i = 1; i < 8; i++) begin
            if (use_xnor_s) begin
                chain[i] = ~(chain[i-1] ^ bus.data[i]);
            end else begin
                chain[i] = chain[i-1] ^ bus.data[i];
            end
        end
        qm_s = {~use_xnor_s, chain};
    end

    // Stage 1 register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mode_r <= MODE_CTRL;
            sync_r <= 2'b00;
            qm_r   <= 9'd0;
        end else begin
            mode_r <= bus.mode;
            sync_r <= bus.sync;
            qm_r   <= qm_s;
        end
    end

`ifdef TMDS_TERC4_EN
    // TERC4 nibble travels alongside the other stage 1 controls.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_r <= 4'h0;
        end else begin
            ctrl_r <= bus.ctrl;
        end
    end
`endif

    tmds_popcount8 u_pop_qm (.bits(qm_r[7:0]), .count(n1_s));

    assign n0_s   = 4'd8 - n1_s;
    assign diff_s = {2'b00, n1_s} - {2'b00, n0_s};
    assign q_s    = qm_r[7:0];

    // DC balancing for video; every other word type resets the disparity.
    always_comb begin
        out_s = CTRL_00;
        cnt_s = 6'd0;
        case (mode_r)
            MODE_VIDEO: begin
                if ((cnt_r == 6'd0) || (n1_s == n0_s)) begin
                    out_s = {~qm_r[8], qm_r[8], qm_r[8] ? q_s : ~q_s};
                    if (qm_r[8]) begin
                        cnt_s = cnt_r + diff_s;
                    end else begin
                        cnt_s = cnt_r - diff_s;
                    end
                end else if ((!cnt_r[5] && (n1_s > n0_s)) || (cnt_r[5] && (n0_s > n1_s))) begin
                    // Running disparity would grow: send inverted.
                    out_s = {1'b1, qm_r[8], ~q_s};
                    cnt_s = cnt_r + {4'b0000, qm_r[8], 1'b0} - diff_s;
                end else begin
                    out_s = {1'b0, qm_r[8], q_s};
                    cnt_s = cnt_r - {4'b0000, ~qm_r[8], 1'b0} + diff_s;
                end
            end
            MODE_GUARD: begin
                out_s = GUARD_WORD;
            end
            MODE_TERC4: begin
`ifdef TMDS_TERC4_EN
                out_s = terc4_code(ctrl_r);
`else
                out_s = ctrl_token(sync_r);
`endif
            end
            default: begin
                out_s = ctrl_token(sync_r);
            end
        endcase
    end

    // Stage 2 register: symbol and running disparity.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_r <= CTRL_00;
            cnt_r <= 6'd0;
        end else begin
            out_r <= out_s;
            cnt_r <= cnt_s;
        end
    end

    assign bus.out  = out_r;
    assign bus.disp = cnt_r;

endmodule

// File: tb/tb_tmds_8b10b_encoder.sv
// Directed bench for tmds_8b10b_encoder: channel 0 and channel 1 instances
// driven with identical words.
module tb_tmds_8b10b_encoder;
    import tmds_pkg::*;

    logic clk;
    logic reset_n;
    int   tests;
    int   fails;

    tmds_8b10b_encoder_if bus0 ();
    tmds_8b10b_encoder_if bus1 ();

    tmds_8b10b_encoder #(.CHANNEL(0)) dut0 (.clk(clk), .reset_n(reset_n), .bus(bus0));
    tmds_8b10b_encoder #(.CHANNEL(1)) dut1 (.clk(clk), .reset_n(reset_n), .bus(bus1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [9:0] obs, input logic [9:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input tmds_mode_e m, input logic [7:0] d, input logic [1:0] s, input logic [3:0] c);
        bus0.mode = m; bus0.data = d; bus0.sync = s; bus0.ctrl = c;
        bus1.mode = m; bus1.data = d; bus1.sync = s; bus1.ctrl = c;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Receiver-side decode: undo inversion (bit 9), then XOR/XNOR (bit 8).
    function automatic logic [7:0] sw_decode(input logic [9:0] w);
        logic [7:0] q;
        logic [7:0] d;
        q    = w[9] ? ~w[7:0] : w[7:0];
        d    = 8'h00;
        d[0] = q[0];
        for (int i = 1; i < 8; i++) begin
            d[i] = w[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
        end
        return d;
    endfunction

    initial begin
        logic [1:0] syncs [3];
        logic [9:0] toks  [3];
        logic [9:0] v_out [3];
        logic [9:0] v_dsp [3];
        logic [9:0] exp_t4a;
        logic [9:0] exp_t4b;
        int sd;

        tests = 0;
        fails = 0;
        syncs = '{2'b01, 2'b10, 2'b11};
        toks  = '{10'h0AB, 10'h154, 10'h2AB};
        v_out = '{10'h100, 10'h3FF, 10'h100};
        v_dsp = '{10'h038, 10'h002, 10'h03A};   // -8, 2, -6 as 6-bit
`ifdef TMDS_TERC4_EN
        exp_t4a = 10'h29C;
        exp_t4b = 10'h11E;
`else
        exp_t4a = 10'h354;
        exp_t4b = 10'h0AB;
`endif

        // 1. Reset.
        reset_n = 1'b0;
        drive(MODE_CTRL, 8'h00, 2'b00, 4'h0);
        repeat (3) step();
        check("rst_out",   bus0.out, 10'h354);
        check("rst_disp",  {4'b0000, bus0.disp}, 10'h000);
        check("rst_out1",  bus1.out, 10'h354);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("post_rst_out", bus0.out, 10'h354);
        end

        // 2. Control tokens, two edges of latency.
        for (int i = 0; i < 4; i++) begin
            if (i < 3) drive(MODE_CTRL, 8'h00, syncs[i], 4'h0);
            step();
            if (i >= 1) begin
                check("ctrl_tok",  bus0.out, toks[i-1]);
                check("ctrl_tok1", bus1.out, toks[i-1]);
            end
        end

        // 3. VIDEO 0x00 x3 from zero disparity.
        drive(MODE_VIDEO, 8'h00, 2'b00, 4'h0);
        for (int i = 0; i < 4; i++) begin
            step();
            if (i >= 1) begin
                check("vid00_out",  bus0.out, v_out[i-1]);
                check("vid00_disp", {4'b0000, bus0.disp}, v_dsp[i-1]);
            end
        end

        // 4. Sweep 0..255 twice, decode every symbol, bound disparity.
        for (int i = 0; i <= 512; i++) begin
            if (i < 512) drive(MODE_VIDEO, 8'(i), 2'b00, 4'h0);
            step();
            if (i >= 1) begin
                check("sweep_dec", {2'b00, sw_decode(bus0.out)}, {2'b00, 8'(i - 1)});
                check("sweep_even", {9'd0, bus0.disp[0]}, 10'd0);
                sd = int'($signed(bus0.disp));
                check("sweep_bound", {9'd0, (sd <= 16 && sd >= -16)}, 10'd1);
            end
        end

        // 5. CTRL mid-stream zeroes disparity; async reset mid-stream.
        drive(MODE_VIDEO, 8'hA5, 2'b00, 4'h0);
        step();
        drive(MODE_CTRL, 8'h00, 2'b00, 4'h0);
        step();
        drive(MODE_VIDEO, 8'h00, 2'b00, 4'h0);
        step();
        check("mid_ctrl_out",  bus0.out, 10'h354);
        check("mid_ctrl_disp", {4'b0000, bus0.disp}, 10'h000);
        drive(MODE_VIDEO, 8'hFF, 2'b00, 4'h0);
        step();
        check("after_ctrl_out",  bus0.out, 10'h100);
        check("after_ctrl_disp", {4'b0000, bus0.disp}, 10'h038);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_out",  bus0.out, 10'h354);
        check("async_rst_disp", {4'b0000, bus0.disp}, 10'h000);
        drive(MODE_CTRL, 8'h00, 2'b00, 4'h0);
        step();
        reset_n = 1'b1;
        step();

        // 6. Guard bands per channel, then TERC4 mode.
        drive(MODE_GUARD, 8'h00, 2'b00, 4'h0);
        step();
        step();
        check("guard_ch0",  bus0.out, 10'h2CC);
        check("guard_ch1",  bus1.out, 10'h133);
        check("guard_disp", {4'b0000, bus0.disp}, 10'h000);
        drive(MODE_TERC4, 8'h00, 2'b00, 4'h0);
        step();
        drive(MODE_TERC4, 8'h00, 2'b01, 4'h5);
        step();
        check("terc4_0", bus0.out, exp_t4a);
        step();
        check("terc4_5", bus0.out, exp_t4b);
        check("terc4_disp", {4'b0000, bus0.disp}, 10'h000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
